// File: rtl/stage_result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : stage_result_pipe
// Purpose  : Pipeline-stage result selector and register. Picks one of NSRC
//            result sources (or the link value pc+LINK_OFFSET), computes the
//            effective write enable and registers everything into the next
//            stage. The registered outputs also serve as a forwarding source.
//            Supports stall (hold) and flush (bubble insertion).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous active-high reset
//   stall      in   1            hold current contents
//   flush      in   1            load a bubble (wins over stall)
//   in_valid   in   1            incoming instruction is real
//   in_we      in   1            incoming instruction writes a register
//   in_addr    in   A_W          destination register number
//   sel        in   SEL_W        source index
//   link_sel   in   1            select pc+LINK_OFFSET, overrides sel
//   src_flat   in   NSRC*WIDTH   source k at [k*WIDTH +: WIDTH]
//   pc         in   WIDTH        PC of incoming instruction
//   out_valid  out  1            registered valid
//   out_we     out  1            registered effective write enable
//   out_addr   out  A_W          registered destination
//   out_data   out  WIDTH        registered selected result
//   out_pc     out  WIDTH        registered PC
// Optional (macro STAGE_RESULT_PIPE_STAT_EN):
//   stat_stall_cnt   out 32      saturating count of stalled cycles
//   stat_bubble_cnt  out 32      saturating count of bubbles loaded
// ============================================================================
module stage_result_pipe #(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 4,
  parameter int SEL_W       = 2,
  parameter int A_W         = 5,
  parameter int LINK_OFFSET = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic                    in_we,
  input  logic [A_W-1:0]          in_addr,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    link_sel,
  input  logic [NSRC*WIDTH-1:0]   src_flat,
  input  logic [WIDTH-1:0]        pc,
  output logic                    out_valid,
  output logic                    out_we,
  output logic [A_W-1:0]          out_addr,
  output logic [WIDTH-1:0]        out_data,
  output logic [WIDTH-1:0]        out_pc
`ifdef STAGE_RESULT_PIPE_STAT_EN
  ,
  output logic [31:0]             stat_stall_cnt,
  output logic [31:0]             stat_bubble_cnt
`endif
);

  localparam logic [WIDTH-1:0] C_LINK_OFFSET = WIDTH'(LINK_OFFSET);

  logic [WIDTH-1:0] w_nxt_data;
  logic             w_nxt_we;

  logic             r_valid;
  logic             r_we;
  logic [A_W-1:0]   r_addr;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_pc;

  // Result selection. An out-of-range sel matches no source and leaves the
  // default of zero in place.
  always_comb begin
    w_nxt_data = '0;
    if (link_sel) begin
      w_nxt_data = pc + C_LINK_OFFSET;
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        if (sel == SEL_W'(k)) begin
          w_nxt_data = src_flat[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Register 0 is hard-wired, so a write to it is never reported.
  assign w_nxt_we = in_valid & in_we & (in_addr != '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_we    <= w_nxt_we;
      r_addr  <= in_addr;
      r_data  <= w_nxt_data;
      r_pc    <= pc;
    end
  end

  assign out_valid = r_valid;
  assign out_we    = r_we;
  assign out_addr  = r_addr;
  assign out_data  = r_data;
  assign out_pc    = r_pc;

`ifdef STAGE_RESULT_PIPE_STAT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // A bubble is either an explicit flush or a load of an invalid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else if (stall) begin
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
    end else if (!in_valid) begin
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stat_stall_cnt  = r_stall_cnt;
  assign stat_bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_result_pipe
// Purpose  : Self-checking bench for stage_result_pipe. A reference model
//            predicts the registered outputs for each driven cycle, pushes
//            them to a queue, and a monitor pops and compares them after the
//            edge. Scenario tasks add their own direct checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_result_pipe;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
    logic [31:0] sc;
    logic [31:0] bc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, in_we, link_sel;
  logic [4:0]  in_addr;
  logic [1:0]  sel;
  logic [31:0] pc;
  logic [31:0] src [4];
  logic [127:0] src_flat;
  logic [95:0]  src_flat3;

  logic        out_valid, out_we;
  logic [4:0]  out_addr;
  logic [31:0] out_data, out_pc;
  logic        d3_valid, d3_we;
  logic [4:0]  d3_addr;
  logic [31:0] d3_data, d3_pc;
`ifdef STAGE_RESULT_PIPE_STAT_EN
  logic [31:0] stat_stall_cnt, stat_bubble_cnt, d3_sc, d3_bc;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  exp_t m;

  assign src_flat  = {src[3], src[2], src[1], src[0]};
  assign src_flat3 = {src[2], src[1], src[0]};

  always #5 clk = ~clk;

  stage_result_pipe dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_addr(in_addr), .sel(sel),
    .link_sel(link_sel), .src_flat(src_flat), .pc(pc),
    .out_valid(out_valid), .out_we(out_we), .out_addr(out_addr),
    .out_data(out_data), .out_pc(out_pc)
`ifdef STAGE_RESULT_PIPE_STAT_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_bubble_cnt(stat_bubble_cnt)
`endif
  );

  stage_result_pipe #(.NSRC(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_addr(in_addr), .sel(sel),
    .link_sel(link_sel), .src_flat(src_flat3), .pc(pc),
    .out_valid(d3_valid), .out_we(d3_we), .out_addr(d3_addr),
    .out_data(d3_data), .out_pc(d3_pc)
`ifdef STAGE_RESULT_PIPE_STAT_EN
    , .stat_stall_cnt(d3_sc), .stat_bubble_cnt(d3_bc)
`endif
  );

  // Reference model of the 4-source instance: next register contents.
  function automatic exp_t model_next(exp_t cur);
    exp_t n = cur;
    if (reset) begin
      n = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    end else if (flush) begin
      n.v = 1'b0; n.we = 1'b0; n.a = 5'd0; n.d = 32'd0; n.pc = 32'd0;
      if (cur.bc != 32'hFFFF_FFFF) n.bc = cur.bc + 1;
    end else if (stall) begin
      if (cur.sc != 32'hFFFF_FFFF) n.sc = cur.sc + 1;
    end else begin
      n.v  = in_valid;
      n.we = in_valid && in_we && (in_addr != 5'd0);
      n.a  = in_addr;
      n.d  = link_sel ? (pc + 32'd8) : src[sel];
      n.pc = pc;
      if (!in_valid && cur.bc != 32'hFFFF_FFFF) n.bc = cur.bc + 1;
    end
    return n;
  endfunction

  task automatic tick();
    m = model_next(m);
    q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected entry per clock edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (out_valid !== e.v) begin
        miscompares++; $display("FAIL sb_valid: got %b expected %b", out_valid, e.v);
      end
      vectors++;
      if (out_we !== e.we) begin
        miscompares++; $display("FAIL sb_we: got %b expected %b", out_we, e.we);
      end
      vectors++;
      if (out_addr !== e.a) begin
        miscompares++; $display("FAIL sb_addr: got %h expected %h", out_addr, e.a);
      end
      vectors++;
      if (out_data !== e.d) begin
        miscompares++; $display("FAIL sb_data: got %h expected %h", out_data, e.d);
      end
      vectors++;
      if (out_pc !== e.pc) begin
        miscompares++; $display("FAIL sb_pc: got %h expected %h", out_pc, e.pc);
      end
`ifdef STAGE_RESULT_PIPE_STAT_EN
      vectors++;
      if (stat_stall_cnt !== e.sc) begin
        miscompares++; $display("FAIL sb_stall_cnt: got %0d expected %0d", stat_stall_cnt, e.sc);
      end
      vectors++;
      if (stat_bubble_cnt !== e.bc) begin
        miscompares++; $display("FAIL sb_bubble_cnt: got %0d expected %0d", stat_bubble_cnt, e.bc);
      end
`endif
    end
  end

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; in_we = 1'b1;
    in_addr = 5'd7; sel = 2'd1; link_sel = 1'b0; pc = 32'h100;
    for (int i = 0; i < 4; i++) src[i] = 32'h1000 + i;
    tick(); tick();
    vectors++;
    if ({out_valid, out_we, out_addr, out_data, out_pc} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b we=%b a=%h d=%h pc=%h expected all 0",
               out_valid, out_we, out_addr, out_data, out_pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    src[2] = 32'h1234; sel = 2'd2; in_valid = 1'b1; in_we = 1'b1; in_addr = 5'd5;
    tick();
    vectors++;
    if (out_data !== 32'h1234 || out_we !== 1'b1 || out_addr !== 5'd5 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL load_sel2: got d=%h we=%b a=%h v=%b expected d=1234 we=1 a=05 v=1",
               out_data, out_we, out_addr, out_valid);
    end
  endtask

  task automatic test_link();
    link_sel = 1'b1; sel = 2'd1; pc = 32'h0000_3000;
    tick();
    vectors++;
    if (out_data !== 32'h0000_3008) begin
      miscompares++; $display("FAIL link_add: got %h expected 00003008", out_data);
    end
    pc = 32'hFFFF_FFFC;
    tick();
    vectors++;
    if (out_data !== 32'h0000_0004 || out_pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL link_wrap: got d=%h pc=%h expected d=00000004 pc=fffffffc", out_data, out_pc);
    end
    link_sel = 1'b0;
  endtask

  task automatic test_stall();
    sel = 2'd0; src[0] = 32'hAAAA; pc = 32'h40;
    tick();
    src[0] = 32'h5555; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_data !== 32'hAAAA) begin
        miscompares++; $display("FAIL stall_hold: got %h expected 0000aaaa", out_data);
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (out_data !== 32'h5555) begin
      miscompares++; $display("FAIL stall_release: got %h expected 00005555", out_data);
    end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_we !== 1'b0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_over_stall: got v=%b we=%b d=%h expected 0 0 0", out_valid, out_we, out_data);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_zero_addr();
    in_addr = 5'd0; in_we = 1'b1; in_valid = 1'b1;
    tick();
    vectors++;
    if (out_we !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL zero_addr: got we=%b v=%b expected we=0 v=1", out_we, out_valid);
    end
    in_addr = 5'd9; in_valid = 1'b0;
    tick();
    vectors++;
    if (out_we !== 1'b0 || out_valid !== 1'b0 || out_addr !== 5'd9) begin
      miscompares++;
      $display("FAIL invalid_in: got we=%b v=%b a=%h expected 0 0 09", out_we, out_valid, out_addr);
    end
    in_valid = 1'b1;
  endtask

  task automatic test_sel_range();
    sel = 2'd3; src[3] = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if (out_data !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL sel3_nsrc4: got %h expected deadbeef", out_data);
    end
    vectors++;
    if (d3_data !== 32'd0) begin
      miscompares++; $display("FAIL sel3_nsrc3: got %h expected 00000000", d3_data);
    end
    sel = 2'd2; src[2] = 32'h0BAD_F00D;
    tick();
    vectors++;
    if (d3_data !== 32'h0BAD_F00D) begin
      miscompares++; $display("FAIL sel2_nsrc3: got %h expected 0badf00d", d3_data);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_we = 1'b1; in_addr = 5'd3; sel = 2'd1; src[1] = 32'h77; pc = 32'h200;
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    vectors++;
    if ({out_valid, out_we, out_addr, out_data, out_pc} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b we=%b a=%h d=%h expected all 0", out_valid, out_we, out_addr, out_data);
    end
`ifdef STAGE_RESULT_PIPE_STAT_EN
    vectors++;
    if (stat_stall_cnt !== 32'd0 || stat_bubble_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got s=%0d b=%0d expected 0 0", stat_stall_cnt, stat_bubble_cnt);
    end
`endif
    reset = 1'b0;
    tick();
    vectors++;
    if (out_data !== 32'd0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_then_stall: got d=%h v=%b expected 0 0", out_data, out_valid);
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (out_data !== 32'h77 || out_addr !== 5'd3) begin
      miscompares++; $display("FAIL post_reset_load: got d=%h a=%h expected 77 03", out_data, out_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      in_we    = $urandom_range(0, 1);
      in_addr  = 5'($urandom_range(0, 31));
      sel      = 2'($urandom_range(0, 3));
      link_sel = ($urandom_range(0, 5) == 0);
      pc       = $urandom;
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      tick();
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    m = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    test_reset();
    test_load();
    test_link();
    test_stall();
    test_flush();
    test_zero_addr();
    test_sel_range();
    test_reset_mid();
    test_random();
    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
